// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: sequencer state encoding, round counter width,
// round constants and the byte-level round transforms used by the sequencer.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_KEY,
    ST_STATE,
    ST_FIN
  } fsm_e;

  localparam int unsigned ROUND_W = 4;
  typedef logic [ROUND_W-1:0] round_t;

  // Round constant for rounds 1..10; zero outside that range.
  function automatic logic [7:0] rcon(input round_t r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Byte n = row + 4*col lives at [127-8n -: 8].
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // t is the substituted, rotated word already combined with rcon.
  function automatic logic [127:0] key_expand_step(input logic [127:0] rk, input logic [31:0] t);
    logic [31:0] w0, w1, w2, w3;
    w0 = rk[127:96] ^ t;
    w1 = rk[95:64]  ^ w0;
    w2 = rk[63:32]  ^ w1;
    w3 = rk[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/Sub_Bytes.sv
// Sixteen parallel AES S-boxes, computed as GF(2^8) inverse (a^254)
// followed by the affine transform.
module Sub_Bytes
  import aes_pkg::*;
(
  input  logic [127:0] i_data,
  output logic [127:0] o_data
);

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    logic [7:0] p;
    logic [7:0] inv;
    x = gf_mul(a, a);
    p = x;
    for (int unsigned i = 0; i < 6; i++) begin
      x = gf_mul(x, x);
      p = gf_mul(p, x);
    end
    inv = p;
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Substitute every byte of the 128-bit word.
  always_comb begin
    o_data = '0;
    for (int unsigned n = 0; n < 16; n++) begin
      o_data[127-8*n -: 8] = sbox(i_data[127-8*n -: 8]);
    end
  end

endmodule

// File: rtl/aes_key_step.sv
// One on-the-fly AES-128 key expansion step: (round key, SubWord result, rcon)
// -> next round key.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] i_rk,
  input  logic [31:0]  i_sb_word,
  input  logic [7:0]   i_rcon,
  output logic [127:0] o_rk
);

  logic [31:0] w_t;

  // Fold rcon into the substituted word, then chain the four words.
  always_comb begin
    w_t  = i_sb_word ^ {i_rcon, 24'h0};
    o_rk = key_expand_step(i_rk, w_t);
  end

endmodule

// File: rtl/aes128_round_sched.sv
// Iterative AES-128 encryption sequencer. A single Sub_Bytes bank is shared
// between the key schedule (KEY cycle) and the cipher state (STATE cycle),
// giving two cycles per round over NR rounds.
// Optional: define AES_ABORT_EN to add an abort input that cancels a block.
module aes128_round_sched
  import aes_pkg::*;
#(
  parameter int unsigned NR = 10
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [127:0] data_in,
`ifdef AES_ABORT_EN
  input  logic         abort,
`endif
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [127:0] data_out
);

  generate
    if (NR != 10) begin : g_nr_check
      $error("aes128_round_sched: NR must be 10 for AES-128");
    end
  endgenerate

  localparam round_t LP_NR = round_t'(NR);

  fsm_e         r_fsm;
  round_t       r_round;
  logic [127:0] r_state;
  logic [127:0] r_rk;
  logic [127:0] r_dout;
  logic         r_ready;
  logic         r_busy;
  logic         r_done;

  logic [127:0] w_sb_in;
  logic [127:0] w_sb_out;
  logic [127:0] w_rk_next;
  logic [127:0] w_sr;
  logic [127:0] w_mc;
  logic [7:0]   w_rcon;
  logic         w_abort;

`ifdef AES_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // S-box operand: rotated last key word in KEY, cipher state in STATE.
  always_comb begin
    w_sb_in = '0;
    case (r_fsm)
      ST_KEY:   w_sb_in = {rot_word(r_rk[31:0]), 96'h0};
      ST_STATE: w_sb_in = r_state;
      default:  w_sb_in = '0;
    endcase
  end

  Sub_Bytes u_sub_bytes (
    .i_data (w_sb_in),
    .o_data (w_sb_out)
  );

  assign w_rcon = rcon(r_round);

  aes_key_step u_key_step (
    .i_rk      (r_rk),
    .i_sb_word (w_sb_out[127:96]),
    .i_rcon    (w_rcon),
    .o_rk      (w_rk_next)
  );

  assign w_sr = shift_rows(w_sb_out);
  assign w_mc = mix_columns(w_sr);

  // Sequencer with registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fsm   <= ST_IDLE;
      r_round <= '0;
      r_state <= '0;
      r_rk    <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_fsm)
        ST_IDLE: begin
          if (start) begin
            r_state <= data_in ^ key_in;
            r_rk    <= key_in;
            r_round <= round_t'(1);
            r_fsm   <= ST_KEY;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_KEY: begin
          if (w_abort) begin
            r_fsm   <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_rk  <= w_rk_next;
            r_fsm <= ST_STATE;
          end
        end
        ST_STATE: begin
          if (w_abort) begin
            r_fsm   <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else if (r_round == LP_NR) begin
            r_state <= w_sr ^ r_rk;
            r_fsm   <= ST_FIN;
            r_busy  <= 1'b0;
          end else begin
            r_state <= w_mc ^ r_rk;
            r_round <= r_round + round_t'(1);
            r_fsm   <= ST_KEY;
          end
        end
        ST_FIN: begin
          r_dout  <= r_state;
          r_done  <= 1'b1;
          r_fsm   <= ST_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_fsm   <= ST_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ready    = r_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign data_out = r_dout;

endmodule

// File: doc/aes128_round_sched.md
Name: aes128_round_sched

Overview:
- Iterative AES-128 encryption sequencer built around one shared combinational Sub_Bytes instance (128-bit in, 128-bit out).
- Time-multiplexes that S-box bank between the on-the-fly key schedule (SubWord) and the cipher state (SubBytes): two cycles per round, 10 rounds.
- Sits between the host-side block interface and the existing round-function primitives.

Parameters:
- NR, 10, number of rounds; fixed for AES-128 and checked at elaboration.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; accepted only when ready=1
- key_in  input  128  cipher key, byte 0 in [127:120]
- data_in  input  128  plaintext block, byte 0 in [127:120], column-major
- ready  output  1  high in IDLE only
- busy  output  1  high in KEY and STATE
- done  output  1  one-cycle pulse when data_out is updated
- data_out  output  128  ciphertext; held until the next done

Behaviour:
- Reset (rst_n=0 at a clk edge) sets fsm=IDLE, round=0, state=0, rk=0, data_out=0, done=0, busy=0, ready=1. Reset mid-operation abandons the block with no done.
- FSM states are IDLE, KEY, STATE, FIN.
- IDLE, start=1: state <= data_in ^ key_in; rk <= key_in; round <= 1; go to KEY. In IDLE, start=0 stays in IDLE.
- KEY:
  - S-box input = {RotWord(rk[31:0]), 96'h0}; t = sb_out[127:96].
  - rk <= expand(rk, t ^ {rcon[round],24'h0}), i.e. w0' = w0^t', w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - Go to STATE.
- STATE:
  - S-box input = state.
  - If round<NR: state <= MixColumns(ShiftRows(sb_out)) ^ rk; round <= round+1; go to KEY.
  - If round==NR: state <= ShiftRows(sb_out) ^ rk (MixColumns skipped); go to FIN.
- FIN: data_out <= state; done <= 1 for this single cycle; go to IDLE.
- S-box input in IDLE/FIN is 128'h0.
- rcon: 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
- Latency: start sampled at edge 0; done and the new data_out are visible after edge 21. Throughput is one block per 22 cycles.
- start while busy or in FIN is ignored and not queued. start in the same cycle as done is not accepted (ready=0 in FIN).
- key_in and data_in are sampled only on the accepting edge; later changes have no effect.
- round is a 4-bit counter and never wraps; the NR comparison ends the sequence.

Optional Feature:
- Macro: AES_ABORT_EN.
- With it defined:
  - Adds input abort (1 bit).
  - abort=1 in KEY or STATE makes the next state IDLE.
  - No done pulse; data_out keeps its previous value; state and rk are left unchanged.
  - abort in IDLE/FIN has no effect.
  - abort and rst_n=0 in the same cycle: reset wins.
- Without it: no abort port; every accepted block runs to completion.

Decomposition:
- Shared package aes_pkg holds:
  - the FSM state enum and round counter width;
  - the rcon table;
  - functions xtime, shift_rows, mix_columns, rot_word, key_expand_step.
- Sub_Bytes is instantiated once inside this block; no second S-box instance is allowed.
- One new sub-module is natural: aes_key_step, combinational, (rk, sbox word, rcon) -> next rk.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> done after 21 cycles, data_out 3925841d02dc09fbdc118597196a0b32. Internal state: 193de3bea0f4e22b9ac68d2ae9f84808 after load, a49c7ff2689f352b6b5bea43026a5049 after round 1.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> data_out 69c4e0d86a7b0430d8cdb78070b4c55a.
- start pulsed every cycle while busy, and key_in/data_in toggled -> single done at cycle 21 with the App. B result; next block accepted only after ready returns.
- rst_n=0 at cycle 9 of a block -> outputs reset values, no done. A following App. C.1 block -> correct ciphertext.
- AES_ABORT_EN: abort at cycle 5 -> IDLE next cycle, no done, data_out keeps its prior ciphertext. Immediate restart -> correct result.
- Back-to-back blocks: start asserted continuously -> done every 22 cycles, each data_out matching its reference model.
